// File: rtl/max_pooling_buf.sv
// max_pooling_buf: forms stride-2 2x2 windows from a binary raster stream
// one line buffer row plus two registers of horizontal history
module max_pooling_buf #(
  parameter int IMG_W = 24,
  parameter int IMG_H = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic valid_in,
  input  logic pixel_in,
  output logic pixel_0,
  output logic pixel_1,
  output logic pixel_2,
  output logic pixel_3,
  output logic valid_out_buf,
  output logic frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_WMAX = CW'(2 * (IMG_W / 2) - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          line_buf [IMG_W];
  logic          top_prev;
  logic          cur_prev;
  logic          line_rd;
  logic          col_end;
  logic          row_end;
  logic          win_hit;

  // previous-row pixel at this column, and window/frame position decode
  always_comb begin
    line_rd = line_buf[col];
    col_end = (col == COL_LAST);
    row_end = (row == ROW_LAST);
    win_hit = row[0] & col[0] & (col <= COL_WMAX);
  end

  // raster position; col wraps into row, row wraps at frame end
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (valid_in) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // line buffer: not reset, row 0 always fills it before any read
  always_ff @(posedge clk) begin
    if (!rst && valid_in) begin
      line_buf[col] <= pixel_in;
    end
  end

  // history registers and registered window / frame-end outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      top_prev      <= 1'b0;
      cur_prev      <= 1'b0;
      pixel_0       <= 1'b0;
      pixel_1       <= 1'b0;
      pixel_2       <= 1'b0;
      pixel_3       <= 1'b0;
      valid_out_buf <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      valid_out_buf <= 1'b0;
      frame_done    <= 1'b0;
      if (valid_in) begin
        top_prev   <= line_rd;
        cur_prev   <= pixel_in;
        frame_done <= col_end & row_end;
        if (win_hit) begin
          valid_out_buf <= 1'b1;
          pixel_0       <= top_prev;
          pixel_1       <= line_rd;
          pixel_2       <= cur_prev;
          pixel_3       <= pixel_in;
        end
      end
    end
  end

endmodule
